// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite initiator: turns a valid/ready command stream into
// pipelined NONSEQ/IDLE transfers and returns read data on a one-cycle strobe.
module ahb_master #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 busy
);

    typedef enum logic {
        AP_IDLE   = 1'b0,
        AP_NONSEQ = 1'b1
    } ap_state_t;

    typedef enum logic [1:0] {
        DP_NONE  = 2'b00,
        DP_WRITE = 2'b01,
        DP_READ  = 2'b10
    } dp_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    ap_state_t              ap_state_r;
    ap_state_t              ap_next_s;
    dp_state_t              dp_state_r;
    dp_state_t              dp_next_s;
    logic [addrWidth-1:0]   haddr_r;
    logic                   hwrite_r;
    logic [1:0]             htrans_r;
    logic [dataWidth-1:0]   wdata_r;
    logic [dataWidth-1:0]   hwdata_r;
    logic                   rsp_valid_r;
    logic [dataWidth-1:0]   rsp_rdata_r;
    logic                   busy_r;
    logic                   accept_s;

    // A command can only be taken when the bus is not stalling.
    assign cmd_ready = hready;
    assign accept_s  = hready & cmd_valid;

    assign haddr     = haddr_r;
    assign hwrite    = hwrite_r;
    assign htrans    = htrans_r;
    assign hwdata    = hwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign busy      = busy_r;

    // Address-phase next state: advances only on hready edges.
    always_comb begin
        ap_next_s = ap_state_r;
        if (hready) begin
            if (cmd_valid) begin
                ap_next_s = AP_NONSEQ;
            end else begin
                ap_next_s = AP_IDLE;
            end
        end else begin
            ap_next_s = ap_state_r;
        end
    end

    // Data-phase next state: inherits the current address phase on hready edges.
    always_comb begin
        dp_next_s = dp_state_r;
        if (hready) begin
            case (ap_state_r)
                AP_NONSEQ: dp_next_s = hwrite_r ? DP_WRITE : DP_READ;
                AP_IDLE:   dp_next_s = DP_NONE;
                default:   dp_next_s = DP_NONE;
            endcase
        end else begin
            dp_next_s = dp_state_r;
        end
    end

    // State registers plus registered bus-facing outputs.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            ap_state_r  <= AP_IDLE;
            dp_state_r  <= DP_NONE;
            haddr_r     <= {addrWidth{1'b0}};
            hwrite_r    <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            wdata_r     <= {dataWidth{1'b0}};
            hwdata_r    <= {dataWidth{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {dataWidth{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            ap_state_r <= ap_next_s;
            dp_state_r <= dp_next_s;
            htrans_r   <= (ap_next_s == AP_NONSEQ) ? HTRANS_NONSEQ : HTRANS_IDLE;
            busy_r     <= (ap_next_s == AP_NONSEQ) || (dp_next_s != DP_NONE);
            if (accept_s) begin
                haddr_r  <= cmd_addr;
                hwrite_r <= cmd_write;
                wdata_r  <= cmd_wdata;
            end
            // hwdata changes only when a write enters its data phase, so it is
            // naturally held across stalls and idle cycles.
            if (hready && (ap_state_r == AP_NONSEQ) && hwrite_r) begin
                hwdata_r <= wdata_r;
            end
            if (hready && (dp_state_r == DP_READ)) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= hrdata;
            end else begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: vector table for the unstalled pipeline,
// hand sequences for stalls and mid-transfer reset, with a simple memory responder.
module tb_ahb_master;

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    ahb_master #(.addrWidth(8), .dataWidth(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Bench responder: tracks the data phase itself and serves a word memory.
    logic [31:0] mem [256];
    logic        r_valid;
    logic        r_write;
    logic [7:0]  r_addr;
    logic        ovr_en;
    logic [31:0] ovr_data;

    assign hrdata = ovr_en ? ovr_data : mem[r_addr];

    always @(posedge hclk) begin
        if (!hresetn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 8'h00;
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
        end else if (hready) begin
            if (r_valid && r_write) mem[r_addr] <= hwdata;
            r_valid <= (htrans == 2'b10);
            r_write <= hwrite;
            r_addr  <= haddr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic rdy);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        hready    = rdy;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [1:0]  e_htrans;
        logic        e_hwrite;
        logic [7:0]  e_haddr;
        logic [31:0] e_hwdata;
        logic        e_busy;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic w, input logic [7:0] a,
                                input logic [31:0] d, input logic [1:0] et,
                                input logic ew, input logic [7:0] ea,
                                input logic [31:0] ehw, input logic eb,
                                input logic erv, input logic [31:0] erd);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.d = d;
        t.e_htrans = et; t.e_hwrite = ew; t.e_haddr = ea; t.e_hwdata = ehw;
        t.e_busy = eb; t.e_rv = erv; t.e_rd = erd;
        return t;
    endfunction

    vec_t vecs [18];

    initial begin
        // Idle, write/read 0x10, then 4 writes + 4 reads back-to-back; all hready=1.
        vecs[0]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 2'b10, 1'b1, 8'h10, 32'h0,        1'b1, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 8'h10, 32'h0,        2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF);
        vecs[6]  = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF);
        vecs[7]  = mk(1'b1, 1'b1, 8'h00, 32'h1,        2'b10, 1'b1, 8'h00, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF);
        vecs[8]  = mk(1'b1, 1'b1, 8'h01, 32'h2,        2'b10, 1'b1, 8'h01, 32'h1,        1'b1, 1'b0, 32'hDEADBEEF);
        vecs[9]  = mk(1'b1, 1'b1, 8'h02, 32'h3,        2'b10, 1'b1, 8'h02, 32'h2,        1'b1, 1'b0, 32'hDEADBEEF);
        vecs[10] = mk(1'b1, 1'b1, 8'h03, 32'h4,        2'b10, 1'b1, 8'h03, 32'h3,        1'b1, 1'b0, 32'hDEADBEEF);
        vecs[11] = mk(1'b1, 1'b0, 8'h00, 32'h0,        2'b10, 1'b0, 8'h00, 32'h4,        1'b1, 1'b0, 32'hDEADBEEF);
        vecs[12] = mk(1'b1, 1'b0, 8'h01, 32'h0,        2'b10, 1'b0, 8'h01, 32'h4,        1'b1, 1'b0, 32'hDEADBEEF);
        vecs[13] = mk(1'b1, 1'b0, 8'h02, 32'h0,        2'b10, 1'b0, 8'h02, 32'h4,        1'b1, 1'b1, 32'h1);
        vecs[14] = mk(1'b1, 1'b0, 8'h03, 32'h0,        2'b10, 1'b0, 8'h03, 32'h4,        1'b1, 1'b1, 32'h2);
        vecs[15] = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h03, 32'h4,        1'b1, 1'b1, 32'h3);
        vecs[16] = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h03, 32'h4,        1'b0, 1'b1, 32'h4);
        vecs[17] = mk(1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h03, 32'h4,        1'b0, 1'b0, 32'h4);

        ovr_en   = 1'b0;
        ovr_data = 32'h0;
        hresetn  = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        step();
        chk("rst_htrans", {30'h0, htrans}, 32'h0);
        chk("rst_haddr", {24'h0, haddr}, 32'h0);
        chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        hresetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, 1'b1);
            chk($sformatf("v%0d_cmd_ready", i), {31'h0, cmd_ready}, 32'h1);
            step();
            chk($sformatf("v%0d_htrans", i), {30'h0, htrans}, {30'h0, vecs[i].e_htrans});
            chk($sformatf("v%0d_hwrite", i), {31'h0, hwrite}, {31'h0, vecs[i].e_hwrite});
            chk($sformatf("v%0d_haddr", i), {24'h0, haddr}, {24'h0, vecs[i].e_haddr});
            chk($sformatf("v%0d_hwdata", i), hwdata, vecs[i].e_hwdata);
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].e_busy});
            chk($sformatf("v%0d_rsp_valid", i), {31'h0, rsp_valid}, {31'h0, vecs[i].e_rv});
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
        end

        // Write 0x20 in data phase with read 0x24 in address phase, stalled 3 cycles.
        drive(1'b1, 1'b1, 8'h20, 32'h55AA55AA, 1'b1);
        step();
        drive(1'b1, 1'b0, 8'h24, 32'h0, 1'b1);
        step();
        chk("wr_dp_hwdata", hwdata, 32'h55AA55AA);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 1'b0);
            chk($sformatf("stall%0d_cmd_ready", i), {31'h0, cmd_ready}, 32'h0);
            step();
            chk($sformatf("stall%0d_htrans", i), {30'h0, htrans}, 32'h2);
            chk($sformatf("stall%0d_haddr", i), {24'h0, haddr}, 32'h24);
            chk($sformatf("stall%0d_hwrite", i), {31'h0, hwrite}, 32'h0);
            chk($sformatf("stall%0d_hwdata", i), hwdata, 32'h55AA55AA);
            chk($sformatf("stall%0d_busy", i), {31'h0, busy}, 32'h1);
            chk($sformatf("stall%0d_mem20", i), mem[8'h20], 32'h0);
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        chk("wr_done_mem20", mem[8'h20], 32'h55AA55AA);
        chk("wr_done_htrans", {30'h0, htrans}, 32'h0);
        chk("wr_done_haddr", {24'h0, haddr}, 32'h24);
        chk("wr_done_busy", {31'h0, busy}, 32'h1);

        // Read 0x24 now in data phase: stall 2 cycles, then complete with 0x12345678.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
            step();
            chk($sformatf("rd_stall%0d_rsp_valid", i), {31'h0, rsp_valid}, 32'h0);
            chk($sformatf("rd_stall%0d_busy", i), {31'h0, busy}, 32'h1);
        end
        ovr_en   = 1'b1;
        ovr_data = 32'h12345678;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        ovr_en = 1'b0;
        chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd_busy", {31'h0, busy}, 32'h0);
        step();
        chk("rd_rsp_valid_once", {31'h0, rsp_valid}, 32'h0);

        // Reset while a read sits in its data phase: it must vanish without a response.
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
        chk("mid_rst_htrans", {30'h0, htrans}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst%0d_rsp_valid", i), {31'h0, rsp_valid}, 32'h0);
            chk($sformatf("post_rst%0d_htrans", i), {30'h0, htrans}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_master.md
Name: ahb_master

Overview:
- Single-transfer AHB-Lite initiator. It converts a simple valid/ready command stream (read or write, one word each) into pipelined NONSEQ/IDLE bus transfers toward ahb_slave-style responders.
- It returns read data on a one-cycle response strobe.
- It sits between test/traffic generators and the AHB fabric.
- Supported: single transfers, 32-bit words, full address/data-phase pipelining at one transfer per cycle.
- Not supported: bursts, hsize, hresp.

Parameters:
- addrWidth, 8, width of haddr and cmd_addr.
- dataWidth, 32, width of hwdata/hrdata/cmd_wdata/rsp_rdata.

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hresetn  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on edge where cmd_valid&&cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  addrWidth  transfer address.
- cmd_wdata  input  dataWidth  write data (ignored for reads).
- haddr  output  addrWidth  AHB address-phase address.
- hwrite  output  1  AHB address-phase direction.
- htrans  output  2  AHB transfer type; only IDLE=2'b00 and NONSEQ=2'b10 are driven.
- hwdata  output  dataWidth  AHB data-phase write data.
- hready  input  1  AHB ready from responder; 0 stalls both phases.
- hrdata  input  dataWidth  AHB read data.
- rsp_valid  output  1  one-cycle pulse: read completed.
- rsp_rdata  output  dataWidth  read data, valid while rsp_valid.
- busy  output  1  address or data phase outstanding.

Behaviour:
- Reset: hclk edge with hresetn=0 clears all state.
  - Output values: htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - Reset mid-operation drops any pending address/data phase. No rsp_valid is produced for a dropped transfer.
- Address-phase FSM, states AP_IDLE and AP_NONSEQ:
  - htrans=NONSEQ only in AP_NONSEQ.
  - Transition is taken only on an edge with hready=1. The next state is AP_NONSEQ if cmd_valid, else AP_IDLE.
  - When accepting, haddr/hwrite load from cmd_addr/cmd_write and wdata is captured internally.
- cmd_ready = hready (combinational). No command is accepted while stalled.
- Address-phase stall: while hready=0, haddr/hwrite/htrans hold stable.
- Data-phase FSM, states DP_NONE, DP_WRITE and DP_READ:
  - On an edge with hready=1, the data phase loads from the current address phase: AP_NONSEQ with hwrite gives DP_WRITE; AP_NONSEQ with !hwrite gives DP_READ; AP_IDLE gives DP_NONE.
  - While hready=0, the data-phase state holds.
- hwdata:
  - Driven with the captured wdata from the first cycle of DP_WRITE.
  - Held stable until the edge where hready=1 completes it.
  - Holds its last value otherwise.
- Read completion: on an edge with hready=1 in DP_READ, rsp_rdata<=hrdata and rsp_valid<=1 for exactly one cycle. Otherwise rsp_valid<=0.
- Latency:
  - Command accepted at edge N puts the address phase on the bus during cycle N+1.
  - The data phase follows at N+2 when there is no stall.
  - A read gives rsp_valid in cycle N+3 (one cycle after the data-phase completing edge).
  - Each hready=0 cycle adds one.
- Throughput: back-to-back commands give one NONSEQ per cycle. The address phase of transfer k+1 overlaps the data phase of transfer k.
- Write followed by read to the same address is issued in order. No forwarding; the responder orders them.
- busy = (AP_NONSEQ) || (DP_WRITE/DP_READ).

Test Plan:
- Reset, then hready=1 with no commands -> htrans=IDLE every cycle, cmd_ready=1, busy=0, rsp_valid never 1.
- Write addr 0x10 data 0xDEADBEEF, then read 0x10, against ahb_slave with slv_busy=0:
  - Bus shows NONSEQ/hwrite=1/haddr=0x10, then NONSEQ/hwrite=0/haddr=0x10 with hwdata=0xDEADBEEF in that cycle.
  - rsp_valid pulses once with rsp_rdata=0xDEADBEEF.
- Four back-to-back writes to 0x00..0x03 (data 0x1..0x4), then four back-to-back reads:
  - htrans=NONSEQ for 8 consecutive cycles.
  - 4 rsp_valid pulses on consecutive cycles returning 0x1..0x4 in order.
- hready held 0 for 3 cycles during the data phase of write 0x20/0x55AA55AA, using a bench responder model:
  - haddr/htrans/hwdata stay constant and cmd_ready=0 during the stall.
  - Write completes on the first hready=1 edge.
- Read stalled 2 cycles with the bench responder presenting 0x12345678 on the completing edge -> rsp_valid exactly once, rsp_rdata=0x12345678.
- hresetn driven 0 for one edge while a read is in its data phase -> next cycle htrans=IDLE and busy=0; no rsp_valid appears afterward.
